// File: rtl/tx_frame_decoder_if.sv
// FIFO read port and decoded-word handshake of tx_frame_decoder.
// master = decoder side, slave = FIFO / consumer side.
interface tx_frame_decoder_if;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic [15:0] data_out;
    logic [1:0]  chan;
    logic        data_avail;
    logic        data_accept;

    modport master (
        input  rdata, rempty, data_accept,
        output rinc, data_out, chan, data_avail
    );

    modport slave (
        output rdata, rempty, data_accept,
        input  rinc, data_out, chan, data_avail
    );
endinterface

// File: rtl/tx_frame_decoder.sv
// Decodes 3-byte frames (header, MSB, LSB) from a FWFT FIFO into {chan, word}; word valid 3 cycles after header pop.
// Holds the word until data_accept and stops popping meanwhile; optional byte-gap abort under TX_FRAME_DECODER_TIMEOUT_EN.
module tx_frame_decoder #(
    parameter logic [5:0]  HEADER_TAG = 6'b101010,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    tx_frame_decoder_if.master  bus,
    output logic [7:0]          err_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        GET_MSB = 2'd1,
        GET_LSB = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  msb_q, msb_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  chan_q, chan_d;
    logic [7:0]  err_q, err_d;
    logic        pop;
    logic        err_inc;

`ifdef TX_FRAME_DECODER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
    logic [15:0] gap_q, gap_d;
`endif

    // rst gates the pop so no byte leaves the FIFO during a reset cycle.
    assign pop = (state_q != HOLD) && !bus.rempty && !rst;

    always_comb begin
        state_d = state_q;
        msb_d   = msb_q;
        data_d  = data_q;
        chan_d  = chan_q;
        err_inc = 1'b0;

        case (state_q)
            HUNT: begin
                if (pop) begin
                    if (bus.rdata[7:2] == HEADER_TAG) begin
                        chan_d  = bus.rdata[1:0];
                        state_d = GET_MSB;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            GET_MSB: begin
                if (pop) begin
                    msb_d   = bus.rdata;
                    state_d = GET_LSB;
                end
            end
            GET_LSB: begin
                if (pop) begin
                    data_d  = {msb_q, bus.rdata};
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.data_accept) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

`ifdef TX_FRAME_DECODER_TIMEOUT_EN
        gap_d = 16'd0;
        if ((state_q == GET_MSB) || (state_q == GET_LSB)) begin
            if (!pop) begin
                gap_d = gap_q + 16'd1;
                if (gap_d == TIMEOUT_L) begin
                    state_d = HUNT;
                    err_inc = 1'b1;
                    gap_d   = 16'd0;
                end
            end
        end
`endif

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            msb_q   <= 8'h00;
            data_q  <= 16'h0000;
            chan_q  <= 2'd0;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            msb_q   <= msb_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
        end
    end

`ifdef TX_FRAME_DECODER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= 16'd0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign bus.rinc       = pop;
    assign bus.data_out   = data_q;
    assign bus.chan       = chan_q;
    assign bus.data_avail = (state_q == HOLD);
    assign err_count      = err_q;
    assign busy           = (state_q != HUNT);

endmodule

// File: tb/tb_tx_frame_decoder.sv
// Scoreboard bench for tx_frame_decoder: FIFO model feeds directed frames, monitor checks each accepted word.
module tb_tx_frame_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] err_count;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  fifo[$];
    logic [17:0] exp_q[$];

    tx_frame_decoder_if bus ();

    tx_frame_decoder #(
        .HEADER_TAG (6'b101010),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .err_count (err_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        bus.rempty = (fifo.size() == 0);
        bus.rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        refresh();
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [1:0] c);
        exp_q.push_back({d, c});
    endtask

    // rinc is sampled at the edge (pre-update value), FIFO head advances just after.
    task automatic tick();
        logic p;
        @(posedge clk);
        p = bus.rinc;
        #1;
        if (p) begin
            if (fifo.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_on_empty: got rinc=1 expected rinc=0");
            end else begin
                void'(fifo.pop_front());
            end
        end
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every held cycle must have rinc low; every accepted word is scored.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst && bus.data_avail) begin
            check("hold_rinc", {31'd0, bus.rinc}, 32'd0);
            if (bus.data_accept) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h chan %0d expected none", bus.data_out, bus.chan);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", {16'd0, bus.data_out}, {16'd0, e[17:2]});
                    check("word_chan", {30'd0, bus.chan}, {30'd0, e[1:0]});
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.data_accept = 1'b0;
        refresh();
        ticks(3);
        rst = 1'b0;

        // Reset state
        check("rst_avail", {31'd0, bus.data_avail}, 32'd0);
        check("rst_rinc",  {31'd0, bus.rinc}, 32'd0);
        check("rst_data",  {16'd0, bus.data_out}, 32'h0);
        check("rst_chan",  {30'd0, bus.chan}, 32'd0);
        check("rst_err",   {24'd0, err_count}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);

        // Back-to-back frame, latency
        bus.data_accept = 1'b1;
        expect_word(16'h1234, 2'd0);
        push(8'hA8); push(8'h12); push(8'h34);
        tick();
        tick();
        check("lat_n2_avail", {31'd0, bus.data_avail}, 32'd0);
        tick();
        check("lat_n3_avail", {31'd0, bus.data_avail}, 32'd1);
        ticks(3);
        check("t1_err",  {24'd0, err_count}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Held word under backpressure, then second frame
        bus.data_accept = 1'b0;
        expect_word(16'hBEEF, 2'd1);
        expect_word(16'h0001, 2'd3);
        push(8'hA9); push(8'hBE); push(8'hEF);
        push(8'hAB); push(8'h00); push(8'h01);
        ticks(13);
        check("t2_hold_avail", {31'd0, bus.data_avail}, 32'd1);
        check("t2_hold_data",  {16'd0, bus.data_out}, 32'hBEEF);
        check("t2_hold_chan",  {30'd0, bus.chan}, 32'd1);
        check("t2_fifo_left",  fifo.size(), 32'd3);
        bus.data_accept = 1'b1;
        ticks(10);
        check("t2_err", {24'd0, err_count}, 32'd0);

        // Garbage then resync
        expect_word(16'hA855, 2'd0);
        push(8'h00); push(8'hFF); push(8'hA8);
        push(8'hA8); push(8'h55); push(8'h66);
        ticks(12);
        check("t3_err",  {24'd0, err_count}, 32'd3);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_fifo", fifo.size(), 32'd0);

        // Saturating error counter
        for (int i = 0; i < 300; i++) push(8'h00);
        ticks(100);
        check("t4_err_mid", {24'd0, err_count}, 32'h67);
        ticks(210);
        check("t4_err_sat", {24'd0, err_count}, 32'hFF);
        check("t4_avail",   {31'd0, bus.data_avail}, 32'd0);

        // Reset mid-frame
        push(8'hAA); push(8'h77); push(8'h88);
        ticks(2);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rinc_rst", {31'd0, bus.rinc}, 32'd0);
        tick();
        fifo.delete();
        refresh();
        rst = 1'b0;
        check("t5_data", {16'd0, bus.data_out}, 32'h0);
        check("t5_chan", {30'd0, bus.chan}, 32'd0);
        check("t5_err",  {24'd0, err_count}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        expect_word(16'h0102, 2'd0);
        push(8'hA8); push(8'h01); push(8'h02);
        ticks(8);
        check("t5_err_post", {24'd0, err_count}, 32'd0);

        // Starved frame
        push(8'hAA); push(8'h77);
        ticks(22);
`ifdef TX_FRAME_DECODER_TIMEOUT_EN
        check("t6_err",  {24'd0, err_count}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        expect_word(16'h0102, 2'd0);
`else
        check("t6_err",  {24'd0, err_count}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd1);
        expect_word(16'h77A8, 2'd2);
`endif
        push(8'hA8); push(8'h01); push(8'h02);
        ticks(12);
`ifdef TX_FRAME_DECODER_TIMEOUT_EN
        check("t6_err_post", {24'd0, err_count}, 32'd1);
`else
        check("t6_err_post", {24'd0, err_count}, 32'd2);
`endif
        check("t6_busy_post", {31'd0, busy}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
